// File: rtl/fma16_unpack.sv
// fma16 operand-issue stage: operand substitution, fp16 field unpack, iterative subnormal normalization.
// Optional classification logic (xcls/ycls/zcls/invalid_pre) is built when FMA16_UNPACK_CLASS_EN is defined.
module fma16_unpack #(
  parameter int SHIFT_PER_CYCLE = 1,
  parameter int EXP_W           = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      x,
  input  logic [15:0]      y,
  input  logic [15:0]      z,
  input  logic             mul,
  input  logic             add,
  input  logic             negp,
  input  logic             negz,
  input  logic [1:0]       roundmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             xs,
  output logic             ys,
  output logic             zs,
  output logic             ps,
  output logic [EXP_W-1:0] xe,
  output logic [EXP_W-1:0] ye,
  output logic [EXP_W-1:0] ze,
  output logic [10:0]      xm,
  output logic [10:0]      ym,
  output logic [10:0]      zm,
  output logic [3:0]       xcls,
  output logic [3:0]       ycls,
  output logic [3:0]       zcls,
  output logic             invalid_pre,
  output logic [1:0]       rm_q
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [EXP_W-1:0] unpack_e(input logic [15:0] w);
    if (w[14:10] == 5'd0) return (w[9:0] == 10'd0) ? '0 : EXP_W'(1);
    return EXP_W'(w[14:10]);
  endfunction

  function automatic logic [10:0] unpack_m(input logic [15:0] w);
    return {(w[14:10] != 5'd0), w[9:0]};
  endfunction

  function automatic int lzc11(input logic [10:0] m);
    int n;
    n = 11;
    for (int i = 0; i <= 10; i++) if (m[i]) n = 10 - i;
    return n;
  endfunction

  // One normalization step: shift by at most SHIFT_PER_CYCLE, exponent tracks the shift.
  function automatic logic [EXP_W+10:0] norm_step(input logic signed [EXP_W-1:0] e,
                                                  input logic [10:0] m);
    int k;
    k = lzc11(m);
    if (k > SHIFT_PER_CYCLE) k = SHIFT_PER_CYCLE;
    if (m[10] || (m == 11'd0)) k = 0;
    return {e - EXP_W'(k), m << k};
  endfunction

  function automatic logic needs_norm(input logic [10:0] m);
    return !m[10] && (m != 11'd0);
  endfunction

  logic        accept;
  logic [15:0] xw, yw, zw;
  logic        zs_in, ps_in;
  logic [10:0] xm_u, ym_u, zm_u;
  logic        any_sub;
  logic signed [EXP_W-1:0] xe_n, ye_n, ze_n;
  logic [10:0] xm_n, ym_n, zm_n;
  logic        norm_done;

  assign in_ready  = reset_n & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);

  assign xw    = x;
  assign yw    = mul ? y : 16'h3C00;
  assign zw    = add ? z : 16'h0000;
  assign zs_in = zw[15] ^ negz;
  assign ps_in = xw[15] ^ yw[15] ^ negp;

  assign xm_u    = unpack_m(xw) & {11{(xw[14:0] != 15'd0)}};
  assign ym_u    = unpack_m(yw) & {11{(yw[14:0] != 15'd0)}};
  assign zm_u    = unpack_m(zw) & {11{(zw[14:0] != 15'd0)}};
  assign any_sub = needs_norm(xm_u) | needs_norm(ym_u) | needs_norm(zm_u);

  always_comb begin
    {xe_n, xm_n} = norm_step(xe, xm);
    {ye_n, ym_n} = norm_step(ye, ym);
    {ze_n, zm_n} = norm_step(ze, zm);
  end
  assign norm_done = !needs_norm(xm_n) && !needs_norm(ym_n) && !needs_norm(zm_n);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = any_sub ? NORM : DONE;
      NORM:    if (norm_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? (any_sub ? NORM : DONE) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture on accept, then iterate normalization while in NORM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xs   <= 1'b0; ys <= 1'b0; zs <= 1'b0; ps <= 1'b0;
      xe   <= '0;   ye <= '0;   ze <= '0;
      xm   <= '0;   ym <= '0;   zm <= '0;
      rm_q <= '0;
    end else if (accept) begin
      xs   <= xw[15];
      ys   <= yw[15];
      zs   <= zs_in;
      ps   <= ps_in;
      xe   <= unpack_e(xw);
      ye   <= unpack_e(yw);
      ze   <= unpack_e(zw);
      xm   <= xm_u;
      ym   <= ym_u;
      zm   <= zm_u;
      rm_q <= roundmode;
    end else if (state == NORM) begin
      xe <= xe_n; ye <= ye_n; ze <= ze_n;
      xm <= xm_n; ym <= ym_n; zm <= zm_n;
    end
  end

`ifdef FMA16_UNPACK_CLASS_EN
  function automatic logic [3:0] classify(input logic [15:0] w);
    logic emax, fz, nan;
    emax = (w[14:10] == 5'h1F);
    fz   = (w[9:0] == 10'd0);
    nan  = emax && !fz;
    return {nan && !w[9], nan, emax && fz, (w[14:10] == 5'd0) && fz};
  endfunction

  logic [3:0] xc_in, yc_in, zc_in;
  logic       inv_in;

  assign xc_in  = classify(xw);
  assign yc_in  = classify(yw);
  assign zc_in  = classify(zw);
  assign inv_in = xc_in[3] | yc_in[3] | zc_in[3] |
                  (xc_in[1] & yc_in[0]) | (xc_in[0] & yc_in[1]) |
                  ((xc_in[1] | yc_in[1]) & zc_in[1] & (ps_in != zs_in));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xcls <= '0; ycls <= '0; zcls <= '0; invalid_pre <= 1'b0;
    end else if (accept) begin
      xcls <= xc_in; ycls <= yc_in; zcls <= zc_in; invalid_pre <= inv_in;
    end
  end
`else
  assign xcls        = 4'd0;
  assign ycls        = 4'd0;
  assign zcls        = 4'd0;
  assign invalid_pre = 1'b0;
`endif

endmodule
